// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-address / read-data channel bundle.
// The same bundle describes a cache-side requester link and the shared
// master link toward the AXI bridge. The "master" modport issues
// AR and consumes R; the "slave" modport accepts AR and returns R.
interface axi_rd_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter: shares one AXI4 AR/R channel pair between the
// instruction cache (i_req) and the data cache (d_req). One requester is
// granted at a time; the grant is held from the idle-cycle decision until
// the beat carrying RLAST. Contention is resolved round-robin.
module axi_rd_arbiter #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1,
  parameter logic [2:0] AR_SIZE = 3'b010
) (
  input  logic             clk,
  input  logic             rst,
  axi_rd_arbiter_if.slave  i_req,
  axi_rd_arbiter_if.slave  d_req,
  axi_rd_arbiter_if.master m_axi,
  output logic             rd_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rd_err_q, rd_err_d;

  logic [3:0] gnt_id_s;
  logic       gnt_rready_s;
  logic [7:0] gnt_arlen_s;
  logic       ar_hs_s;
  logic       r_beat_s;
  logic       beat_err_s;

  // A beat is malformed when RLAST disagrees with the remaining-beat
  // counter or when it carries the other requester's ID.
  function automatic logic beat_error(input logic       last,
                                      input logic [7:0] cnt,
                                      input logic [3:0] id,
                                      input logic [3:0] exp_id);
    beat_error = (last && (cnt != 8'd0)) ||
                 (!last && (cnt == 8'd0)) ||
                 (id != exp_id);
  endfunction

  // Views of the currently granted requester and the two handshakes.
  always_comb begin
    if (grant_q == GNT_DATA) begin
      gnt_id_s     = ID_DATA;
      gnt_rready_s = d_req.rready;
      gnt_arlen_s  = d_req.arlen;
    end else begin
      gnt_id_s     = ID_INST;
      gnt_rready_s = i_req.rready;
      gnt_arlen_s  = i_req.arlen;
    end
    ar_hs_s  = (state_q == ST_ADDR) && m_axi.arready;
    r_beat_s = (state_q == ST_DATA) && m_axi.rvalid && gnt_rready_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: arbitrate in IDLE, hold ADDR until accepted,
  // hold DATA until the RLAST beat is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req.arvalid || d_req.arvalid) begin
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (ar_hs_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (r_beat_s && m_axi.rlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Grant, round-robin history, beat counter and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q      <= GNT_INST;
      last_grant_q <= GNT_DATA;
      cnt_q        <= 8'd0;
      rd_err_q     <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rd_err_q     <= rd_err_d;
    end
  end

  // Grant selection: a lone requester wins; under contention the port
  // that did not win the previous address phase goes first.
  always_comb begin
    grant_d = grant_q;
    if (state_q == ST_IDLE) begin
      if (i_req.arvalid && d_req.arvalid) begin
        grant_d = ~last_grant_q;
      end else if (d_req.arvalid) begin
        grant_d = GNT_DATA;
      end else if (i_req.arvalid) begin
        grant_d = GNT_INST;
      end else begin
        grant_d = grant_q;
      end
    end else begin
      grant_d = grant_q;
    end

    last_grant_d = last_grant_q;
    if (ar_hs_s) begin
      last_grant_d = grant_q;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Beat counter loads ARLEN on acceptance and counts accepted beats down;
  // malformed beats latch the error flag until reset.
  always_comb begin
    cnt_d      = cnt_q;
    beat_err_s = 1'b0;
    if (ar_hs_s) begin
      cnt_d = gnt_arlen_s;
    end else if (r_beat_s) begin
      beat_err_s = beat_error(m_axi.rlast, cnt_q, m_axi.rid, gnt_id_s);
      if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
    rd_err_d = rd_err_q | beat_err_s;
  end

  // Output routing: master AR carries the granted port's request, R
  // handshakes reach only the granted port; data/last/id are broadcast.
  always_comb begin
    m_axi.arvalid = (state_q == ST_ADDR);
    m_axi.arid    = gnt_id_s;
    m_axi.arlen   = gnt_arlen_s;
    m_axi.arsize  = AR_SIZE;
    m_axi.arburst = 2'b01;
    if (grant_q == GNT_DATA) begin
      m_axi.araddr = d_req.araddr;
    end else begin
      m_axi.araddr = i_req.araddr;
    end
    m_axi.rready = (state_q == ST_DATA) && gnt_rready_s;

    i_req.arready = (state_q == ST_ADDR) && (grant_q == GNT_INST) && m_axi.arready;
    d_req.arready = (state_q == ST_ADDR) && (grant_q == GNT_DATA) && m_axi.arready;
    i_req.rvalid  = (state_q == ST_DATA) && (grant_q == GNT_INST) && m_axi.rvalid;
    d_req.rvalid  = (state_q == ST_DATA) && (grant_q == GNT_DATA) && m_axi.rvalid;

    i_req.rdata = m_axi.rdata;
    i_req.rlast = m_axi.rlast;
    i_req.rid   = m_axi.rid;
    d_req.rdata = m_axi.rdata;
    d_req.rlast = m_axi.rlast;
    d_req.rid   = m_axi.rid;
  end

  assign rd_err = rd_err_q;

endmodule
